// File: rtl/calc_cmd_arbiter_if.sv
// Command arbiter bus: two request sources and calculator status in,
// accept pulses, calculator command and state flags out.
interface calc_cmd_arbiter_if;
    logic [1:0] req;
    logic [3:0] cmd0;
    logic [3:0] cmd1;
    logic [1:0] status_in;
    logic       clear;
    logic [1:0] ack;
    logic [3:0] cmd_out;
    logic       busy;
    logic       err;
    logic       tmo;
    logic       last_src;

    modport master (
        output req, cmd0, cmd1, status_in, clear,
        input  ack, cmd_out, busy, err, tmo, last_src
    );

    modport slave (
        input  req, cmd0, cmd1, status_in, clear,
        output ack, cmd_out, busy, err, tmo, last_src
    );
endinterface

// File: rtl/calc_cmd_arbiter.sv
// Round-robin arbiter between a keypad (source 0) and a host (source 1)
// feeding one calculator command input. A granted command is driven for a
// single ISSUE cycle, then the arbiter waits for the calculator to report
// ready again. Optional feature: define CALC_ARB_TIMEOUT_EN to turn a WAIT
// that never sees ready into an error with a sticky tmo flag.
module calc_cmd_arbiter #(
    parameter logic [3:0] IDLE_CMD = 4'd13,
    parameter int         SETTLE   = 2,
    parameter int         TIMEOUT  = 64
) (
    input  logic              clock,
    input  logic              reset,
    calc_cmd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_READY = 2'b10;
    localparam logic [7:0] SETTLE_C   = SETTLE[7:0];
    localparam logic [7:0] CNT_MAX    = 8'd255;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cmd_q, cmd_d;
    logic       src_q, src_d;
    logic       win_s;

    logic [1:0] ack_q, ack_d;
    logic [3:0] cmd_out_q, cmd_out_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       last_src_q, last_src_d;

`ifdef CALC_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
    logic tmo_q, tmo_d;
`else
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT[7:0];
`endif

    // Next-state, arbitration and output decode; outputs are derived from
    // the next state so they register in the same cycle the state changes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        src_d   = src_q;
`ifdef CALC_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        // preferred source wins if it requests, otherwise the other one
        win_s   = bus.req[ptr_q] ? ptr_q : ~ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.status_in == STAT_ERROR) begin
                    state_d = ST_ERR;
                end else if ((bus.status_in == STAT_READY) && (bus.req != 2'b00)) begin
                    src_d   = win_s;
                    cmd_d   = win_s ? bus.cmd1 : bus.cmd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // completes unconditionally, even on an error status
                ptr_d   = ~src_q;
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 8'd1);
                if (bus.status_in == STAT_ERROR) begin
                    state_d = ST_ERR;
                end else if ((bus.status_in == STAT_READY) && (cnt_q >= SETTLE_C)) begin
                    state_d = ST_IDLE;
`ifdef CALC_ARB_TIMEOUT_EN
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d = ST_ERR;
                    tmo_d   = 1'b1;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d      = 2'b00;
        cmd_out_d  = IDLE_CMD;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        last_src_d = last_src_q;
        case (state_d)
            ST_ISSUE: begin
                ack_d      = src_d ? 2'b10 : 2'b01;
                cmd_out_d  = cmd_d;
                busy_d     = 1'b1;
                last_src_d = src_d;
            end
            ST_WAIT: begin
                busy_d = 1'b1;
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, arbitration pointer, wait counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= 8'd0;
            cmd_q      <= IDLE_CMD;
            src_q      <= 1'b0;
            ack_q      <= 2'b00;
            cmd_out_q  <= IDLE_CMD;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            last_src_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            src_q      <= src_d;
            ack_q      <= ack_d;
            cmd_out_q  <= cmd_out_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            last_src_q <= last_src_d;
        end
    end

`ifdef CALC_ARB_TIMEOUT_EN
    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign bus.tmo = tmo_q;
`else
    assign bus.tmo = 1'b0;
`endif

    assign bus.ack      = ack_q;
    assign bus.cmd_out  = cmd_out_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.last_src = last_src_q;
endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Self-checking bench for calc_cmd_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_calc_cmd_arbiter;
    localparam logic [3:0] IDLE_CMD = 4'd13;
    localparam int         SETTLE   = 2;
    localparam int         TIMEOUT  = 64;
`ifdef CALC_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    calc_cmd_arbiter_if bus();

    calc_cmd_arbiter #(.IDLE_CMD(IDLE_CMD), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: a pending command about to be shown, a command that
    // has been shown and is waiting for the calculator, an error latch.
    bit         m_issue, m_wait, m_err, m_tmo, m_last, m_src, m_pref;
    int         m_n;
    logic [3:0] m_cmd;

    task automatic model_reset();
        m_issue = 0; m_wait = 0; m_err = 0; m_tmo = 0;
        m_last = 0; m_src = 0; m_pref = 0; m_n = 0; m_cmd = IDLE_CMD;
    endtask

    task automatic model_clock();
        if (m_err) begin
            if (bus.clear) m_err = 0;
        end else if (m_issue) begin
            m_pref  = !m_src;
            m_issue = 0;
            m_wait  = 1;
            m_n     = 0;
        end else if (m_wait) begin
            if (bus.status_in == 2'b00) begin
                m_wait = 0; m_err = 1;
            end else if (bus.status_in == 2'b10 && m_n >= SETTLE) begin
                m_wait = 0;
            end else if (TMO_EN && m_n >= TIMEOUT) begin
                m_wait = 0; m_err = 1; m_tmo = 1;
            end
            m_n = (m_n >= 255) ? 255 : m_n + 1;
        end else begin
            if (bus.status_in == 2'b00) begin
                m_err = 1;
            end else if (bus.status_in == 2'b10 && bus.req != 2'b00) begin
                m_src   = bus.req[m_pref] ? m_pref : !m_pref;
                m_cmd   = m_src ? bus.cmd1 : bus.cmd0;
                m_last  = m_src;
                m_issue = 1;
            end
        end
    endtask

    function automatic logic [9:0] expected();
        logic [1:0] a;
        a = m_issue ? (m_src ? 2'b10 : 2'b01) : 2'b00;
        return {a, (m_issue ? m_cmd : IDLE_CMD), logic'(m_issue | m_wait),
                logic'(m_err), logic'(m_tmo), logic'(m_last)};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.ack, bus.cmd_out, bus.busy, bus.err, bus.tmo, bus.last_src};
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [1:0] st, input logic cl);
        bus.req = r; bus.cmd0 = c0; bus.cmd1 = c1; bus.status_in = st; bus.clear = cl;
    endtask

    task automatic test_reset();
        drive(2'b11, 4'd1, 4'd2, 2'b10, 1'b0);
        reset = 1'b0;
        #12;
        model_reset();
        total++;
        if (observed() !== {2'b00, IDLE_CMD, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got %b want %b", observed(), {2'b00, IDLE_CMD, 4'b0000});
        end
        drive(2'b00, 4'd0, 4'd0, 2'b10, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        do_reset();
        drive(2'b01, 4'd7, 4'($urandom_range(0, 15)), 2'b10, 1'b0);
        tick();
        total++;
        if (bus.cmd_out !== 4'd7 || bus.ack !== 2'b01) begin
            bad++;
            $display("FAIL single_issue: got cmd=%0d ack=%b want cmd=7 ack=01", bus.cmd_out, bus.ack);
        end
        bus.req = 2'b00;
        begin
            int busy_n = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                total++;
                if (observed() !== expected()) begin
                    bad++;
                    $display("FAIL single_model: cycle %0d got %b want %b", i, observed(), expected());
                end
                if (bus.busy) busy_n++;
            end
            total++;
            if (busy_n !== SETTLE + 1) begin
                bad++;
                $display("FAIL single_wait_len: got %0d want %0d", busy_n, SETTLE + 1);
            end
        end
    endtask

    task automatic test_alternate();
        logic [3:0] cmds[$];
        logic [1:0] acks[$];
        logic [3:0] want_c[4];
        logic [1:0] want_a[4];
        want_c = '{4'd3, 4'd14, 4'd3, 4'd14};
        want_a = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        drive(2'b11, 4'd3, 4'd14, 2'b10, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL alternate_model: cycle %0d got %b want %b", i, observed(), expected());
            end
            if (bus.ack != 2'b00) begin
                cmds.push_back(bus.cmd_out);
                acks.push_back(bus.ack);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= cmds.size()) begin
                bad++;
                $display("FAIL alternate_seq: grant %0d missing, want cmd=%0d", k, want_c[k]);
            end else if (cmds[k] !== want_c[k] || acks[k] !== want_a[k]) begin
                bad++;
                $display("FAIL alternate_seq: grant %0d got cmd=%0d ack=%b want cmd=%0d ack=%b",
                         k, cmds[k], acks[k], want_c[k], want_a[k]);
            end
        end
        bus.req = 2'b00;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_long_wait();
        int wait_n = 0;
        int extra_ack = 0;
        do_reset();
        drive(2'b01, 4'd10, 4'd5, 2'b10, 1'b0);
        tick();
        total++;
        if (bus.cmd_out !== 4'd10 || bus.ack !== 2'b01) begin
            bad++;
            $display("FAIL long_issue: got cmd=%0d ack=%b want cmd=10 ack=01", bus.cmd_out, bus.ack);
        end
        bus.status_in = 2'b11;
        tick();
        if (bus.busy && bus.ack == 2'b00) wait_n++;
        for (int i = 0; i < 30 && bus.busy; i++) begin
            bus.status_in = (i < 9) ? 2'b11 : 2'b10;
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL long_model: cycle %0d got %b want %b", i, observed(), expected());
            end
            if (bus.ack != 2'b00) extra_ack++;
            if (bus.busy && bus.ack == 2'b00) wait_n++;
        end
        total++;
        if (wait_n !== 10 || extra_ack !== 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL long_wait: got wait=%0d acks=%0d busy=%b want wait=10 acks=0 busy=0",
                     wait_n, extra_ack, bus.busy);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_error();
        do_reset();
        drive(2'b11, 4'd4, 4'd9, 2'b10, 1'b0);
        tick();
        bus.status_in = 2'b11;
        tick();
        bus.status_in = 2'b00;
        tick();
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_out !== IDLE_CMD) begin
            bad++;
            $display("FAIL error_enter: got err=%b busy=%b cmd=%0d want err=1 busy=0 cmd=13",
                     bus.err, bus.busy, bus.cmd_out);
        end
        bus.status_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.ack !== 2'b00 || bus.err !== 1'b1) begin
                bad++;
                $display("FAIL error_hold: cycle %0d got ack=%b err=%b want ack=00 err=1", i, bus.ack, bus.err);
            end
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        total++;
        if (bus.err !== 1'b0 || observed() !== expected()) begin
            bad++;
            $display("FAIL error_clear: got %b want %b", observed(), expected());
        end
        tick();
        total++;
        if (bus.ack !== 2'b10 || bus.cmd_out !== 4'd9 || bus.last_src !== 1'b1) begin
            bad++;
            $display("FAIL error_resume: got ack=%b cmd=%0d last=%b want ack=10 cmd=9 last=1",
                     bus.ack, bus.cmd_out, bus.last_src);
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        drive(2'b01, 4'd6, 4'd0, 2'b10, 1'b0);
        tick();
        bus.req = 2'b00;
        bus.status_in = 2'b01;
        n = TMO_EN ? 100 : 300;
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL timeout_model: cycle %0d got %b want %b", i, observed(), expected());
            end
        end
        total++;
        if (TMO_EN) begin
            if (bus.err !== 1'b1 || bus.tmo !== 1'b1) begin
                bad++;
                $display("FAIL timeout_end: got err=%b tmo=%b want err=1 tmo=1", bus.err, bus.tmo);
            end
        end else begin
            if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.tmo !== 1'b0) begin
                bad++;
                $display("FAIL timeout_end: got busy=%b err=%b tmo=%b want busy=1 err=0 tmo=0",
                         bus.busy, bus.err, bus.tmo);
            end
        end
        bus.clear = 1'b1;
        bus.status_in = 2'b10;
        tick();
        bus.clear = 1'b0;
        total++;
        if (bus.tmo !== logic'(TMO_EN)) begin
            bad++;
            $display("FAIL timeout_sticky: got tmo=%b want %b", bus.tmo, TMO_EN);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        drive(2'b10, 4'd2, 4'd11, 2'b10, 1'b0);
        tick();
        bus.req = 2'b11;
        bus.status_in = 2'b01;
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (observed() !== {2'b00, IDLE_CMD, 4'b0000}) begin
            bad++;
            $display("FAIL abort_async: got %b want %b", observed(), {2'b00, IDLE_CMD, 4'b0000});
        end
        bus.status_in = 2'b10;
        @(posedge clock);
        #1;
        reset = 1'b1;
        total++;
        if (bus.ack !== 2'b00 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: got ack=%b busy=%b want ack=00 busy=0", bus.ack, bus.busy);
        end
        tick();
        total++;
        if (bus.ack !== 2'b01 || bus.cmd_out !== 4'd2) begin
            bad++;
            $display("FAIL abort_regrant: got ack=%b cmd=%0d want ack=01 cmd=2", bus.ack, bus.cmd_out);
        end
    endtask

    function automatic logic [1:0] rand_status();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 2'b00;
            1, 2:    return 2'b01;
            3:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic test_random();
        do_reset();
        drive(2'b00, 4'd0, 4'd0, 2'b10, 1'b0);
        for (int i = 0; i < 800; i++) begin
            drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  rand_status(), ($urandom_range(0, 3) == 0));
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL random_model: cycle %0d got %b want %b", i, observed(), expected());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_long_wait();
        test_error();
        test_timeout();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_cmd_arbiter.md
CALC_CMD_ARBITER -- requirements
Module: calc_cmd_arbiter

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  IDLE_CMD  4'd13  code driven on cmd_out when no command is issued (unused by the calculator)
  SETTLE    2      minimum WAIT cycles before calculator ready is trusted (1..255)
  TIMEOUT   64     WAIT cycles without ready before fault (SETTLE+1..255)
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  clock      in   1  single clock, rising edge
  reset      in   1  asynchronous, active-low reset
  req        in   2  request per source (bit0 keypad, bit1 host)
  cmd0       in   4  command from source 0, stable while req[0]=1
  cmd1       in   4  command from source 1, stable while req[1]=1
  status_in  in   2  calculator status: 00 error, 01 busy, 10 ready, 11 printing
  clear      in   1  leaves ERR state
  ack        out  2  one-cycle accept pulse per source
  cmd_out    out  4  command to calculator cmd input
  busy       out  1  high in ISSUE or WAIT
  err        out  1  high in ERR
  tmo        out  1  sticky timeout flag
  last_src   out  1  source of most recent issued command

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT and ERR.
REQ-004 IDLE: status_in=00 -> ERR; else if status_in=10 and req!=0 -> latch winner's cmd and index, go to ISSUE next cycle; else stay.
REQ-005 Arbitration SHALL be round-robin: a pointer names the preferred source; the winner is the preferred source if it requests, otherwise the other.
REQ-006 Pointer SHALL move to the non-winner in the ISSUE cycle and SHALL be unaffected otherwise.
REQ-007 ISSUE: exactly one cycle; cmd_out = latched cmd; ack[winner]=1; last_src=winner; next WAIT with wait counter=0; ISSUE SHALL complete even if status_in=00 that cycle.
REQ-008 Request-to-cmd_out latency SHALL be 1 cycle from the IDLE cycle that grants it.
REQ-009 WAIT: cmd_out=IDLE_CMD; counter increments each cycle (8 bits, saturating at 255); status_in=00 -> ERR (highest priority); counter>=SETTLE and status_in=10 -> IDLE.
REQ-010 ERR: err=1, cmd_out=IDLE_CMD, ack=0; clear=1 -> IDLE next cycle, pointer and tmo unchanged.
REQ-011 cmd_out SHALL equal IDLE_CMD in every state except ISSUE; ack SHALL be 0 except in ISSUE.
REQ-012 A request dropped before ack SHALL be ignored; arbitration SHALL be re-evaluated every IDLE cycle.
REQ-013 Both req bits high with pointer=0 SHALL grant source 0, then source 1 on the next grant (alternation).
REQ-014 Commands SHALL pass unmodified; no cmd value (including IDLE_CMD) is filtered.

Reset
REQ-015 reset=0 SHALL asynchronously force: state IDLE, pointer 0, counter 0, ack 00, cmd_out IDLE_CMD, busy 0, err 0, tmo 0, last_src 0, latched cmd IDLE_CMD.
REQ-016 Reset asserted mid-ISSUE or mid-WAIT SHALL abort without an ack pulse after reset; first grant after release SHALL obey REQ-004 at pointer 0.

Configuration
REQ-017 Macro CALC_ARB_TIMEOUT_EN defined: in WAIT, counter reaching TIMEOUT with status_in!=10 SHALL move to ERR and set tmo (sticky until reset).
REQ-018 CALC_ARB_TIMEOUT_EN undefined: WAIT persists until ready or error; tmo SHALL be constant 0 and no timeout logic SHALL be synthesised.

Verification
REQ-019 Status 10, req=01, cmd0=4'd7 -> next cycle cmd_out=7, ack=01; then cmd_out=13 for >=2 cycles, busy=1 until status 10 seen with counter>=2.
REQ-020 req=11 held, cmd0=3, cmd1=14, status always 10 -> issued sequence 3,14,3,14 with alternating ack 01,10.
REQ-021 ISSUE of cmd 10, then status 11 for 9 cycles, then 10 -> WAIT for 10 cycles, return to IDLE, no second ack meanwhile.
REQ-022 status_in=00 in WAIT -> err=1 next cycle, ack stays 00 with req=11; clear pulse -> IDLE, next grant resumes at stored pointer.
REQ-023 CALC_ARB_TIMEOUT_EN defined, status stuck at 01 after issue -> ERR and tmo=1 at counter 64; undefined -> remains in WAIT for 300 cycles, tmo=0.
REQ-024 reset driven low one cycle after ISSUE -> all outputs at REQ-015 values immediately, no ack after release until new IDLE grant.
